// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the MIPS pipeline.
package mips_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00400000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_q.sv
// Synchronous FIFO of fetched instructions with flush and occupancy count.
module fetch_q
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_push = i_push && !w_full && !i_flush;
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: r_cnt qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: PC, imem requests, epoch-tagged redirects, queue.
// Optional counters enabled by defining FETCH_STATS_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_redirects,
  output logic [31:0]       stat_stall
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inf_pc;
  logic              r_epoch;
  logic              r_inf_epoch;
  logic              r_inflight;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_tgt;

  assign w_unused_tgt = ^redir_target[1:0];

  assign imem_req  = !reset && ((w_count + CW'(r_inflight)) < CW'(QDEPTH));
  assign imem_addr = r_fetch_pc[ADDR_W-1:2];
  assign w_grant   = imem_req && imem_gnt;

  // A stale epoch, a same-cycle redirect or a pre-reset response all drop.
  assign w_push = imem_rvalid && r_inflight && !redir_valid
               && (r_inf_epoch == r_epoch);
  assign w_pop  = inst_valid && inst_ready;

  assign w_push_data = '{pc: 32'(r_inf_pc), inst: imem_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_inf_pc    <= '0;
      r_epoch     <= 1'b0;
      r_inf_epoch <= 1'b0;
      r_inflight  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_inf_pc    <= r_fetch_pc;
        r_inf_epoch <= r_epoch;
      end
      r_inflight <= w_grant || (r_inflight && !imem_rvalid);
      if (redir_valid) begin
        r_fetch_pc <= {redir_target[ADDR_W-1:2], 2'b00};
        r_epoch    <= ~r_epoch;
      end else if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
    end
  end

  fetch_q #(
    .DEPTH (QDEPTH)
  ) u_q (
    .clk     (clk),
    .i_rst   (reset),
    .i_flush (redir_valid),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign inst_valid = (w_count != '0);
  assign inst_data  = w_head.inst;
  assign inst_pc    = w_head.pc[ADDR_W-1:0];
  assign inst_pc4   = inst_pc + ADDR_W'(4);

`ifdef FETCH_STATS_EN
  logic [31:0] r_st_fetch;
  logic [31:0] r_st_redir;
  logic [31:0] r_st_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st_fetch <= '0;
      r_st_redir <= '0;
      r_st_stall <= '0;
    end else begin
      if (w_push)                    r_st_fetch <= r_st_fetch + 32'd1;
      if (redir_valid)               r_st_redir <= r_st_redir + 32'd1;
      if (inst_valid && !inst_ready) r_st_stall <= r_st_stall + 32'd1;
    end
  end

  assign stat_fetched   = r_st_fetch;
  assign stat_redirects = r_st_redir;
  assign stat_stall     = r_st_stall;
`endif

endmodule
